// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: default geometry and the beat-counter width helper for the DDR receive deserializer.
package ddr_rx_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BEATS = 4;
  localparam int DEF_DEPTH = 4;
  function automatic int cnt_w(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/ddr_rx_fifo.sv
// ddr_rx_fifo: synchronous FIFO of entry type T; an extra pointer bit separates full from empty.
module ddr_rx_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign level = wp - rp;
  assign rd = pop && !empty;
  // a push into a full FIFO is still taken when the head leaves on the same edge
  assign wr = push && (!full || rd);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, wr};
      rp <= rp + {{AW{1'b0}}, rd};
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ddr_rx_deserializer.sv
// ddr_rx_deserializer: dual-edge beat capture, LSB-first word packing and an output FIFO.
// Define DDR_RX_DESERIALIZER_PARITY_EN for per-beat odd parity with a per-word error flag.
module ddr_rx_deserializer
  import ddr_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BEATS = DEF_BEATS,
  parameter int FIFO_DEPTH = DEF_DEPTH
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic [WIDTH-1:0] ddr_data_i,
  input  logic ddr_valid_i,
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
  input  logic ddr_par_i,
  output logic word_perr_o,
`endif
  input  logic clear_i,
  output logic [WIDTH*BEATS-1:0] word_data_o,
  output logic word_valid_o,
  input  logic word_ready_i,
  output logic overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);
  localparam int CW = cnt_w(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  typedef struct packed {
    logic valid;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    logic par;
`endif
    logic [WIDTH-1:0] data;
  } beat_t;
  typedef struct packed {
    logic [WIDTH*BEATS-1:0] data;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    logic perr;
`endif
  } entry_t;
  beat_t neg_q, pos_b;
  entry_t din, dout;
  logic [CW-1:0] cnt, c1, c2;
  logic [WIDTH*BEATS-1:0] part, w0, w1;
  logic done0, done1, push, pop, full, empty, ovf;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
  logic perr, perr_n, bad0, bad1, p0;
`endif
  always_comb begin
    pos_b = '0;
    pos_b.valid = ddr_valid_i;
    pos_b.data = ddr_data_i;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    pos_b.par = ddr_par_i;
`endif
  end
  always_ff @(negedge clk_i or posedge arst_i)
    if (arst_i) neg_q <= '0;
    else neg_q <= pos_b;
  // the falling-edge beat is older, so it lands first; a completing first beat restarts at slice 0
  always_comb begin
    w0 = part;
    if (neg_q.valid) w0[int'(cnt)*WIDTH +: WIDTH] = neg_q.data;
    done0 = neg_q.valid && cnt == LAST;
    c1 = neg_q.valid ? (done0 ? '0 : cnt + 1'b1) : cnt;
    w1 = w0;
    if (pos_b.valid) w1[int'(c1)*WIDTH +: WIDTH] = pos_b.data;
    done1 = pos_b.valid && c1 == LAST;
    c2 = pos_b.valid ? (done1 ? '0 : c1 + 1'b1) : c1;
    push = !clear_i && (done0 || done1);
    din = '0;
    din.data = done0 ? w0 : w1;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    bad0 = neg_q.valid && !(^{neg_q.par, neg_q.data});
    bad1 = pos_b.valid && !(^{pos_b.par, pos_b.data});
    p0 = perr | bad0;
    din.perr = done0 ? p0 : p0 | bad1;
    perr_n = done1 ? 1'b0 : done0 ? bad1 : p0 | bad1;
`endif
  end
  assign pop = !empty && word_ready_i;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      cnt <= '0;
      part <= '0;
      ovf <= 1'b0;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
      perr <= 1'b0;
`endif
    end else if (clear_i) begin
      cnt <= '0;
      ovf <= 1'b0;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      cnt <= c2;
      part <= w1;
      ovf <= ovf | (push && full && !pop);
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
      perr <= perr_n;
`endif
    end
  ddr_rx_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(arst_i),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(level_o)
  );
  assign word_valid_o = !empty;
  assign word_data_o = dout.data;
  assign overflow_o = ovf;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
  assign word_perr_o = dout.perr;
`endif
endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// tb_ddr_rx_deserializer: directed vector table plus hand-written reset and parity sequences.
module tb_ddr_rx_deserializer;
  logic clk = 1'b0, arst = 1'b1, ddr_valid = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [7:0] ddr_data = 8'h00;
  logic [31:0] word_data;
  logic word_valid, overflow;
  logic [2:0] level;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
  logic ddr_par = 1'b0;
  logic word_perr;
`endif
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  ddr_rx_deserializer #(.WIDTH(8), .BEATS(4), .FIFO_DEPTH(4)) dut (
    .clk_i(clk),
    .arst_i(arst),
    .ddr_data_i(ddr_data),
    .ddr_valid_i(ddr_valid),
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    .ddr_par_i(ddr_par),
    .word_perr_o(word_perr),
`endif
    .clear_i(clear),
    .word_data_o(word_data),
    .word_valid_o(word_valid),
    .word_ready_i(ready),
    .overflow_o(overflow),
    .level_o(level)
  );
  // b0/b1 = {valid, data} for the falling-edge and rising-edge beat; ctl = {clear, ready}
  typedef struct {
    logic [8:0] b0;
    logic [8:0] b1;
    logic [1:0] ctl;
    logic ev;
    logic [31:0] ed;
    logic [2:0] el;
    logic eo;
  } vec_t;
  vec_t tbl [36];
  task automatic step(input logic [8:0] b0, input logic [8:0] b1, input logic [1:0] ctl,
                      input logic e0 = 1'b0, input logic e1 = 1'b0);
    {ddr_valid, ddr_data} = b0;
    {clear, ready} = ctl;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    ddr_par = ~^b0[7:0] ^ e0;
`endif
    @(negedge clk);
    #1;
    {ddr_valid, ddr_data} = b1;
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    ddr_par = ~^b1[7:0] ^ e1;
`endif
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic ev, input logic [31:0] ed,
                       input logic [2:0] el, input logic eo);
    vecs++;
    if (word_valid !== ev || word_data !== ed || level !== el || overflow !== eo) begin
      errs++;
      $display("FAIL %s: got valid=%0b data=%h level=%0d ovf=%0b, want valid=%0b data=%h level=%0d ovf=%0b",
               nm, word_valid, word_data, level, overflow, ev, ed, el, eo);
    end
  endtask
  initial begin
    tbl = '{
      '{9'h111, 9'h122, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h133, 9'h144, 2'b01, 1'b1, 32'h44332211, 3'd1, 1'b0},
      '{9'h000, 9'h000, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h1A1, 9'h0FF, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h0FF, 9'h1A2, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h0FF, 9'h1A3, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h1A4, 9'h0FF, 2'b01, 1'b1, 32'hA4A3A2A1, 3'd1, 1'b0},
      '{9'h0FF, 9'h0FF, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h0EE, 9'h101, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h102, 9'h103, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h104, 9'h105, 2'b01, 1'b1, 32'h04030201, 3'd1, 1'b0},
      '{9'h106, 9'h107, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h108, 9'h000, 2'b01, 1'b1, 32'h08070605, 3'd1, 1'b0},
      '{9'h000, 9'h000, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h110, 9'h111, 2'b00, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h112, 9'h113, 2'b00, 1'b1, 32'h13121110, 3'd1, 1'b0},
      '{9'h120, 9'h121, 2'b00, 1'b1, 32'h13121110, 3'd1, 1'b0},
      '{9'h122, 9'h123, 2'b00, 1'b1, 32'h13121110, 3'd2, 1'b0},
      '{9'h130, 9'h131, 2'b00, 1'b1, 32'h13121110, 3'd2, 1'b0},
      '{9'h132, 9'h133, 2'b00, 1'b1, 32'h13121110, 3'd3, 1'b0},
      '{9'h140, 9'h141, 2'b00, 1'b1, 32'h13121110, 3'd3, 1'b0},
      '{9'h142, 9'h143, 2'b00, 1'b1, 32'h13121110, 3'd4, 1'b0},
      '{9'h150, 9'h151, 2'b00, 1'b1, 32'h13121110, 3'd4, 1'b0},
      '{9'h152, 9'h153, 2'b00, 1'b1, 32'h13121110, 3'd4, 1'b1},
      '{9'h160, 9'h161, 2'b00, 1'b1, 32'h13121110, 3'd4, 1'b1},
      '{9'h162, 9'h163, 2'b01, 1'b1, 32'h23222120, 3'd4, 1'b1},
      '{9'h000, 9'h000, 2'b01, 1'b1, 32'h33323130, 3'd3, 1'b1},
      '{9'h000, 9'h000, 2'b01, 1'b1, 32'h43424140, 3'd2, 1'b1},
      '{9'h000, 9'h000, 2'b01, 1'b1, 32'h63626160, 3'd1, 1'b1},
      '{9'h000, 9'h000, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b1},
      '{9'h000, 9'h000, 2'b11, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h177, 9'h178, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h199, 9'h199, 2'b11, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h161, 9'h162, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0},
      '{9'h163, 9'h164, 2'b01, 1'b1, 32'h64636261, 3'd1, 1'b0},
      '{9'h000, 9'h000, 2'b01, 1'b0, 32'h00000000, 3'd0, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 32'h0, 3'd0, 1'b0);
    arst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      step(tbl[i].b0, tbl[i].b1, tbl[i].ctl);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo);
    end
    step(9'h1A1, 9'h1A2, 2'b00);
    step(9'h1A3, 9'h1A4, 2'b00);
    step(9'h1B1, 9'h1B2, 2'b00);
    step(9'h1B3, 9'h000, 2'b00);
    check("pre_reset", 1'b1, 32'hA4A3A2A1, 3'd1, 1'b0);
    #1 arst = 1'b1;
    #1 check("in_reset", 1'b0, 32'h0, 3'd0, 1'b0);
    #1 arst = 1'b0;
    step(9'h15A, 9'h15B, 2'b01);
    step(9'h15C, 9'h15D, 2'b01);
    check("post_reset", 1'b1, 32'h5D5C5B5A, 3'd1, 1'b0);
    step(9'h000, 9'h000, 2'b01);
    check("post_reset_pop", 1'b0, 32'h0, 3'd0, 1'b0);
`ifdef DDR_RX_DESERIALIZER_PARITY_EN
    step(9'h1C1, 9'h1C2, 2'b01, 1'b1, 1'b0);
    step(9'h1C3, 9'h1C4, 2'b01);
    check("perr_word", 1'b1, 32'hC4C3C2C1, 3'd1, 1'b0);
    vecs++;
    if (word_perr !== 1'b1) begin
      errs++;
      $display("FAIL perr_bad: got perr=%0b, want 1", word_perr);
    end
    step(9'h1D1, 9'h1D2, 2'b01);
    step(9'h1D3, 9'h1D4, 2'b01);
    check("good_word", 1'b1, 32'hD4D3D2D1, 3'd1, 1'b0);
    vecs++;
    if (word_perr !== 1'b0) begin
      errs++;
      $display("FAIL perr_good: got perr=%0b, want 0", word_perr);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
